// File: rtl/vram_port.sv
// rtl/vram_port.sv - memory-mapped VRAM write port: stepped pointer, write FIFO, border, status.
// Optional fill engine on register +6 when VRAM_PORT_FILL_EN is defined.
module vram_port #(
   parameter logic [15:0] BASE = 16'h0020,
   parameter int          AW   = 16,
   parameter int          DW   = 4,
   parameter int          FAW  = 2
) (
   input  logic          clock_25,
   input  logic          reset_n,
   input  logic [15:0]   io_a,
   input  logic [7:0]    io_d,
   input  logic          io_we,
   input  logic          io_rd,
   output logic          io_sel,
   output logic [7:0]    io_q,
   output logic [AW-1:0] vram_a,
   output logic [DW-1:0] vram_d,
   output logic          vram_w,
   input  logic          vram_rdy,
   output logic [3:0]    border
);

`ifdef VRAM_PORT_FILL_EN
   localparam logic [15:0] NREG = 16'd7;
`else
   localparam logic [15:0] NREG = 16'd6;
`endif
   localparam logic [FAW-1:0] IDX_ONE  = 1;
   localparam logic [FAW:0]   CNT_ONE  = 1;
   localparam logic [FAW:0]   FULL_CNT = CNT_ONE << FAW;

   logic [AW-1:0]    ptr;
   logic [7:0]       step;
   logic [DW-1:0]    last_d;
   logic             ovf;
   logic [AW+DW-1:0] mem [1 << FAW];
   logic [FAW-1:0]   wr_idx;
   logic [FAW-1:0]   rd_idx;
   logic [FAW:0]     count;

   logic [15:0]   off;
   logic [15:0]   ptr16;
   logic [15:0]   ptr_lo;
   logic [15:0]   ptr_hi;
   logic [15:0]   step_ext;
   logic [AW-1:0] ptr_step;
   logic [DW-1:0] push_d;
   logic [7:0]    status;
   logic          wr;
   logic          full;
   logic          empty;
   logic          pop;
   logic          cpu_push;
   logic          fill_push;
   logic          fill_busy;
   logic          push;
   logic          adv;
   logic          unused_ok;

   assign off       = io_a - BASE;
   assign io_sel    = off < NREG;
   assign wr        = io_we && io_sel;
   assign full      = count == FULL_CNT;
   assign empty     = count == '0;
   assign pop       = !empty && vram_rdy;
   assign cpu_push  = wr && off[2:0] == 3'd2;
   // A CPU push always advances the pointer, even when the FIFO drops it.
   assign push      = (cpu_push || fill_push) && (!full || pop);
   assign adv       = cpu_push || fill_push;
   assign push_d    = cpu_push ? io_d[DW-1:0] : last_d;
   assign step_ext  = {{8{step[7]}}, step};
   assign ptr_step  = ptr + step_ext[AW-1:0];
   assign ptr_lo    = {ptr16[15:8], io_d};
   assign ptr_hi    = {io_d, ptr16[7:0]};
   assign status    = {4'b0, fill_busy, ovf, full, empty};
   assign vram_w    = !empty;
   assign vram_a    = mem[rd_idx][AW+DW-1:DW];
   assign vram_d    = mem[rd_idx][DW-1:0];
   assign unused_ok = io_rd ^ (^step_ext) ^ (^ptr_lo) ^ (^ptr_hi);

   always_comb begin
      ptr16         = '0;
      ptr16[AW-1:0] = ptr;
   end

   always_comb begin
      io_q = '0;
      if (io_sel) begin
         case (off[2:0])
            3'd0:    io_q = ptr16[7:0];
            3'd1:    io_q = ptr16[15:8];
            3'd2:    io_q[DW-1:0] = last_d;
            3'd3:    io_q = step;
            3'd4:    io_q = status;
            3'd5:    io_q = {4'b0, border};
            default: io_q = '0;
         endcase
      end
   end

   always_ff @(posedge clock_25) begin
      if (!reset_n) begin
         ptr    <= '0;
         step   <= 8'h01;
         border <= 4'd7;
         last_d <= '0;
         ovf    <= 1'b0;
         wr_idx <= '0;
         rd_idx <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_idx] <= {ptr, push_d};
            wr_idx      <= wr_idx + IDX_ONE;
         end
         if (pop)
            rd_idx <= rd_idx + IDX_ONE;
         if (push && !pop)
            count <= count + CNT_ONE;
         else if (!push && pop)
            count <= count - CNT_ONE;
         if (cpu_push)
            last_d <= io_d[DW-1:0];
         if (cpu_push && full && !pop)
            ovf <= 1'b1;
         else if (wr && off[2:0] == 3'd4)
            ovf <= 1'b0;
         // Explicit pointer writes win over an advance in the same cycle.
         if (wr && off[2:0] == 3'd0)
            ptr <= ptr_lo[AW-1:0];
         else if (wr && off[2:0] == 3'd1)
            ptr <= ptr_hi[AW-1:0];
         else if (adv)
            ptr <= ptr_step;
         if (wr && off[2:0] == 3'd3)
            step <= io_d;
         if (wr && off[2:0] == 3'd5)
            border <= io_d[3:0];
      end
   end

`ifdef VRAM_PORT_FILL_EN
   logic [8:0] fill_cnt;

   assign fill_busy = fill_cnt != 9'd0;
   // A CPU push owns the FIFO slot for its cycle; the fill simply waits.
   assign fill_push = fill_busy && !cpu_push && (!full || pop);

   always_ff @(posedge clock_25) begin
      if (!reset_n)
         fill_cnt <= '0;
      else if (wr && off[2:0] == 3'd6)
         fill_cnt <= (io_d == 8'd0) ? 9'd256 : {1'b0, io_d};
      else if (fill_push)
         fill_cnt <= fill_cnt - 9'd1;
   end
`else
   assign fill_busy = 1'b0;
   assign fill_push = 1'b0;
`endif

endmodule

// File: tb/tb_vram_port.sv
// tb/tb_vram_port.sv - randomized bench for vram_port against a queue-based reference model.
// Honours VRAM_PORT_FILL_EN to model and exercise the fill engine.
module tb_vram_port;

   localparam int B = 'h20;
`ifdef VRAM_PORT_FILL_EN
   localparam int NREG = 7;
`else
   localparam int NREG = 6;
`endif

   logic        clock_25 = 1'b0;
   logic        reset_n  = 1'b0;
   logic [15:0] io_a     = '0;
   logic [7:0]  io_d     = '0;
   logic        io_we    = 1'b0;
   logic        io_rd    = 1'b0;
   logic        io_sel;
   logic [7:0]  io_q;
   logic [15:0] vram_a;
   logic [3:0]  vram_d;
   logic        vram_w;
   logic        vram_rdy = 1'b0;
   logic [3:0]  border;

   always #20 clock_25 = ~clock_25;

   vram_port dut (
      .clock_25 (clock_25),
      .reset_n  (reset_n),
      .io_a     (io_a),
      .io_d     (io_d),
      .io_we    (io_we),
      .io_rd    (io_rd),
      .io_sel   (io_sel),
      .io_q     (io_q),
      .vram_a   (vram_a),
      .vram_d   (vram_d),
      .vram_w   (vram_w),
      .vram_rdy (vram_rdy),
      .border   (border)
   );

   int n_cmp = 0;
   int n_bad = 0;

   int m_ptr, m_step, m_border, m_last, m_ovf, m_fill;
   int qa[$];
   int qd[$];

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int m_off(input int a);
      return (a - B) & 'hFFFF;
   endfunction

   function automatic int m_q(input int a);
      int off = m_off(a);
      if (off >= NREG) return 0;
      case (off)
         0: return m_ptr & 'hFF;
         1: return (m_ptr >> 8) & 'hFF;
         2: return m_last;
         3: return m_step;
         4: return ((m_fill > 0) ? 8 : 0) | (m_ovf << 2) | ((qa.size() == 4) ? 2 : 0) | ((qa.size() == 0) ? 1 : 0);
         5: return m_border;
         default: return 0;
      endcase
   endfunction

   function automatic void m_reset();
      m_ptr = 0; m_step = 1; m_border = 7; m_last = 0; m_ovf = 0; m_fill = 0;
      qa.delete();
      qd.delete();
   endfunction

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic do_reset();
      reset_n = 1'b0; io_we = 1'b0; io_rd = 1'b0; vram_rdy = 1'b0;
      @(negedge clock_25);
      reset_n = 1'b1;
      m_reset();
   endtask

   task automatic cycle(input bit we, input bit rd, input int a, input int d, input bit rdy, input int exp_q = -1);
      int off, old_ptr, nxt, s;
      bit wr, pop, cpu_push, room, fill_go;
      io_we = we; io_rd = rd; io_a = a[15:0]; io_d = d[7:0]; vram_rdy = rdy;
      #1;
      off = m_off(a);
      expect_eq("io_sel", io_sel, off < NREG);
      expect_eq("io_q", io_q, m_q(a));
      if (exp_q >= 0) expect_eq("io_q_spec", io_q, exp_q);
      expect_eq("vram_w", vram_w, qa.size() != 0);
      if (qa.size() != 0) begin
         expect_eq("vram_a", vram_a, qa[0]);
         expect_eq("vram_d", vram_d, qd[0]);
      end
      expect_eq("border", border, m_border);

      wr       = we && off < NREG;
      pop      = qa.size() != 0 && rdy;
      cpu_push = wr && off == 2;
      room     = (qa.size() - int'(pop)) < 4;
      fill_go  = m_fill > 0 && !cpu_push && room;
      old_ptr  = m_ptr;
      s        = (m_step >= 128) ? m_step - 256 : m_step;
      nxt      = (old_ptr + s) & 'hFFFF;
      if (pop) begin
         void'(qa.pop_front());
         void'(qd.pop_front());
      end
      if (cpu_push) begin
         m_last = d & 'hF;
         if (room) begin
            qa.push_back(old_ptr);
            qd.push_back(d & 'hF);
         end else m_ovf = 1;
         m_ptr = nxt;
      end
      if (fill_go) begin
         qa.push_back(old_ptr);
         qd.push_back(m_last);
         m_fill--;
         m_ptr = nxt;
      end
      if (wr) begin
         case (off)
            0: m_ptr = (old_ptr & 'hFF00) | (d & 'hFF);
            1: m_ptr = (old_ptr & 'hFF) | ((d & 'hFF) << 8);
            3: m_step = d & 'hFF;
            4: m_ovf = 0;
            5: m_border = d & 'hF;
            6: m_fill = ((d & 'hFF) == 0) ? 256 : (d & 'hFF);
            default: ;
         endcase
      end
      @(negedge clock_25);
   endtask

   initial begin
      int a;
      m_reset();
      @(negedge clock_25);
      do_reset();

      // Reset state
      expect_eq("reset_border", border, 4'd7);
      expect_eq("reset_vram_w", vram_w, 1'b0);
      cycle(0, 1, B + 4, 0, 0, 'h01);
      cycle(0, 1, B + 3, 0, 0, 'h01);

      // Single write at ptr 1234
      cycle(1, 0, B + 0, 'h34, 0);
      cycle(1, 0, B + 1, 'h12, 0);
      cycle(1, 0, B + 2, 'h05, 1);
      expect_eq("first_a", vram_a, 'h1234);
      expect_eq("first_d", vram_d, 4'h5);
      expect_eq("first_w", vram_w, 1'b1);
      cycle(0, 1, B + 0, 0, 1, 'h35);
      cycle(0, 1, B + 1, 0, 1, 'h12);

      // Negative step wraps below zero
      do_reset();
      cycle(1, 0, B + 3, 'hFF, 1);
      cycle(1, 0, B + 2, 1, 1);
      cycle(1, 0, B + 2, 2, 1);
      cycle(0, 1, B + 0, 0, 1, 'hFE);
      cycle(0, 1, B + 1, 0, 1, 'hFF);

      // Overflow with stalled VRAM, then drain and clear
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1, 0, B + 2, i + 1, 0);
      cycle(0, 1, B + 4, 0, 0, 'h06);
      cycle(0, 1, B + 0, 0, 0, 'h05);
      for (int i = 0; i < 4; i++) cycle(0, 1, B + 4, 0, 1);
      cycle(0, 1, B + 4, 0, 0, 'h05);
      cycle(1, 0, B + 4, 0, 0);
      cycle(0, 1, B + 4, 0, 0, 'h01);

      // Full FIFO, push coinciding with a pop
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1, 0, B + 2, 8 + i, 0);
      cycle(1, 0, B + 2, 'hC, 1);
      cycle(0, 1, B + 4, 0, 0, 'h02);
      for (int i = 0; i < 5; i++) cycle(0, 0, B, 0, 1);

      // Reset mid-drain flushes the queue
      for (int i = 0; i < 3; i++) cycle(1, 0, B + 2, i, 0);
      do_reset();
      expect_eq("flush_vram_w", vram_w, 1'b0);
      cycle(0, 1, B + 4, 0, 1, 'h01);

`ifdef VRAM_PORT_FILL_EN
      do_reset();
      cycle(1, 0, B + 2, 'h0A, 1);
      cycle(1, 0, B + 0, 'h00, 1);
      cycle(1, 0, B + 1, 'h01, 1);
      cycle(1, 0, B + 6, 3, 1);
      for (int i = 0; i < 5; i++) cycle(0, 0, B, 0, 1);
      cycle(0, 1, B + 0, 0, 1, 'h03);
      cycle(0, 1, B + 1, 0, 1, 'h01);
      cycle(0, 1, B + 4, 0, 1, 'h01);
`endif

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(399) == 0) do_reset();
         if ($urandom_range(7) == 0) a = int'($urandom_range(16'hFFFF));
         else a = B - 1 + int'($urandom_range(8));
         cycle($urandom_range(1) == 1, $urandom_range(1) == 1, a, int'($urandom_range(255)),
               $urandom_range(9) < 6);
      end
      for (int i = 0; i < 300; i++) cycle(0, 0, B + 4, 0, 1);
      expect_eq("final_empty", vram_w, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
